mem_stage_ahb: RTL and testbench
================================

MEM_STAGE_AHB -- requirements
Module: mem_stage_ahb

Interface
REQ-001 SHALL have parameter HPROT_VAL, default 4'b0001, the constant driven on HPROT_D.
REQ-002 SHALL have parameter CHECK_ALIGN, default 1; 1 = misaligned accesses trap, 0 = address low bits forced to natural alignment.
REQ-003 SHALL have parameter CNT_W, default 32, the width of the wait-state counter.
REQ-004 SHALL use one clock and a synchronous, active-high reset: CLK input 1, rising-edge clock; RST input 1, synchronous active-high reset.
REQ-005 in_valid input 1, upstream request valid; in_ready output 1, block accepts a request this cycle.
REQ-006 in_pc, in_inst, in_alu, in_rs2, in_csr_data input 32 each: PC, instruction, address/ALU result, store data, CSR read value.
REQ-007 in_rd input 5, destination register; in_is_load, in_is_store, in_is_sys input 1 each, operation class.
REQ-008 HADDR_D, HWDATA_D output 32; HWRITE_D, HMASTLOCK_D output 1; HSIZE_D, HBURST_D output 3; HTRANS_D output 2; HPROT_D output 4: AHB data master.
REQ-009 HRDATA_D input 32, HREADY_D input 1, HRESP_D input 1: AHB slave response.
REQ-010 wb_valid output 1, one-cycle result strobe; wb_pc, wb_inst, wb_data output 32; wb_rd output 5.
REQ-011 wb_exc output 1, result is a trap; wb_cause output 4: 4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault.
REQ-012 wait_cnt output CNT_W, saturating count of bus wait-state cycles.

Function
REQ-013 SHALL implement FSM states IDLE, ADDR, DATA, ERR; in_ready = 1 only in IDLE.
REQ-014 IDLE, accept of non-memory op: next cycle wb_valid=1, wb_data = in_csr_data if in_is_sys else in_alu, wb_exc=0; state stays IDLE.
REQ-015 IDLE, accept of load/store: request registered; if misaligned (half: addr[0]=1; word: addr[1:0]!=0) and CHECK_ALIGN=1, no bus transfer, next cycle wb_valid=1, wb_exc=1, cause 4/6, wb_data=in_alu; else go to ADDR.
REQ-016 ADDR: HTRANS_D=NONSEQ, HADDR_D/HWRITE_D/HSIZE_D from registered request; HSIZE = funct3[1:0] (00 byte, 01 half, 10 word); on HREADY_D=1 go to DATA, else hold all address-phase outputs.
REQ-017 All states except ADDR: HTRANS_D=IDLE; HBURST_D=SINGLE, HMASTLOCK_D=0, HPROT_D=HPROT_VAL always.
REQ-018 DATA: HWDATA_D = SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2, held stable all of DATA.
REQ-019 DATA, HREADY_D=1, HRESP_D=0: completion; next cycle wb_valid=1, wb_exc=0, state IDLE.
REQ-020 Load result: lane = HRDATA_D >> (8*addr[1:0]); funct3 000/001 sign-extend byte/half, 100/101 zero-extend, 010 word; store writes wb_data=in_alu, wb_rd as registered.
REQ-021 DATA, HRESP_D=1, HREADY_D=0: go to ERR; in ERR on HREADY_D=1 go to IDLE with wb_valid=1, wb_exc=1, cause 5 (load) or 7 (store).
REQ-022 DATA, HRESP_D=1 with HREADY_D=1 (protocol violation): treated as error completion immediately, cause 5/7.
REQ-023 wait_cnt increments by 1 each cycle in ADDR or DATA with HREADY_D=0; saturates at all-ones.
REQ-024 Latency, zero wait states: accept cycle T, ADDR T+1, DATA T+2, wb_valid high in T+3; non-memory op wb_valid in T+1.
REQ-025 wb_valid SHALL be exactly one cycle per accepted request; in_valid ignored outside IDLE.

Reset
REQ-026 RST=1 at a clock edge: state IDLE, HTRANS_D=IDLE, wb_valid=0, wb_exc=0, wb_cause=0, wb_pc/wb_inst/wb_data=0, wb_rd=0, wait_cnt=0.
REQ-027 RST mid-transfer (ADDR/DATA/ERR) SHALL abandon the transfer with no wb_valid; in_ready=1 the cycle after RST deasserts.

Verification
REQ-028 LW addr 0x100, HRDATA 0xDEADBEEF, HREADY always 1 -> HTRANS NONSEQ in T+1, wb_valid in T+3, wb_data 0xDEADBEEF.
REQ-029 LB addr 0x103, HRDATA 0x80000000 -> wb_data 0xFFFFFF80; LBU same -> 0x00000080; SH addr 0x102 rs2 0x1234ABCD -> HSIZE 001, HWDATA 0xABCDABCD.
REQ-030 LW addr 0x102, CHECK_ALIGN=1 -> HTRANS stays IDLE, wb_valid T+1, wb_exc=1, cause 4.
REQ-031 SW with HREADY low 3 cycles in DATA -> HWDATA stable, wb_valid after HREADY rises, wait_cnt=3.
REQ-032 LW, two-cycle ERROR (HRESP=1,HREADY=0 then HRESP=1,HREADY=1) -> wb_exc=1, cause 5, back to IDLE.
REQ-033 RST asserted in DATA -> no wb_valid, all outputs at reset values, next LW completes normally.

Source files
------------

// File: rtl/mem_stage_ahb_if.sv
// AHB-Lite data-port bundle between the memory stage (master) and the data-bus slave.
interface mem_stage_ahb_if;
  logic [31:0] HADDR_D;
  logic [31:0] HWDATA_D;
  logic        HWRITE_D;
  logic        HMASTLOCK_D;
  logic [2:0]  HSIZE_D;
  logic [2:0]  HBURST_D;
  logic [1:0]  HTRANS_D;
  logic [3:0]  HPROT_D;
  logic [31:0] HRDATA_D;
  logic        HREADY_D;
  logic        HRESP_D;

  modport master (
    output HADDR_D, HWDATA_D, HWRITE_D, HMASTLOCK_D, HSIZE_D, HBURST_D, HTRANS_D, HPROT_D,
    input  HRDATA_D, HREADY_D, HRESP_D
  );

  modport slave (
    input  HADDR_D, HWDATA_D, HWRITE_D, HMASTLOCK_D, HSIZE_D, HBURST_D, HTRANS_D, HPROT_D,
    output HRDATA_D, HREADY_D, HRESP_D
  );
endinterface

// File: rtl/mem_stage_ahb.sv
// Pipeline memory stage: issues single AHB-Lite transfers for loads/stores and
// produces one write-back strobe per accepted request (results or traps).
module mem_stage_ahb #(
  parameter logic [3:0] HPROT_VAL   = 4'b0001,
  parameter int         CHECK_ALIGN = 1,
  parameter int         CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_alu,
  input  logic [31:0]      in_rs2,
  input  logic [31:0]      in_csr_data,
  input  logic [4:0]       in_rd,
  input  logic             in_is_load,
  input  logic             in_is_store,
  input  logic             in_is_sys,
  mem_stage_ahb_if.master  ahb,
  output logic             wb_valid,
  output logic [31:0]      wb_pc,
  output logic [31:0]      wb_inst,
  output logic [31:0]      wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_exc,
  output logic [3:0]       wb_cause,
  output logic [CNT_W-1:0] wait_cnt
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2, ST_ERR = 2'd3} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t           state_r;
  logic             ready_r;
  logic [31:0]      haddr_r, hwdata_r, alu_r, pc_r, inst_r;
  logic [4:0]       rd_r;
  logic             hwrite_r;
  logic [2:0]       hsize_r;
  logic [1:0]       htrans_r;
  logic             wb_valid_r, wb_exc_r;
  logic [3:0]       wb_cause_r;
  logic [31:0]      wb_pc_r, wb_inst_r, wb_data_r;
  logic [4:0]       wb_rd_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             is_mem_s, misaligned_s;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b01:   is_misaligned = lo[0];
      2'b10:   is_misaligned = (lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] align_addr(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      2'b01:   align_addr = {addr[31:1], 1'b0};
      2'b10:   align_addr = {addr[31:2], 2'b00};
      default: align_addr = addr;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] rs2);
    case (size)
      2'b00:   store_lanes = {4{rs2[7:0]}};
      2'b01:   store_lanes = {2{rs2[15:0]}};
      default: store_lanes = rs2;
    endcase
  endfunction

  // The byte lane is selected by the transfer address, then sign/zero extended by funct3.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rdata);
    logic [31:0] lane;
    lane = rdata >> {lo, 3'b000};
    case (f3)
      3'b000:  load_extract = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_extract = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_extract = {24'h000000, lane[7:0]};
      3'b101:  load_extract = {16'h0000, lane[15:0]};
      default: load_extract = lane;
    endcase
  endfunction

  assign is_mem_s     = in_is_load | in_is_store;
  assign misaligned_s = (CHECK_ALIGN != 0) && is_misaligned(in_inst[13:12], in_alu[1:0]);

  // Request sequencing FSM with all bus and write-back outputs registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      ready_r    <= 1'b1;
      haddr_r    <= 32'h0;
      hwdata_r   <= 32'h0;
      hwrite_r   <= 1'b0;
      hsize_r    <= 3'b000;
      htrans_r   <= HTRANS_IDLE;
      alu_r      <= 32'h0;
      pc_r       <= 32'h0;
      inst_r     <= 32'h0;
      rd_r       <= 5'd0;
      wb_valid_r <= 1'b0;
      wb_exc_r   <= 1'b0;
      wb_cause_r <= 4'd0;
      wb_pc_r    <= 32'h0;
      wb_inst_r  <= 32'h0;
      wb_data_r  <= 32'h0;
      wb_rd_r    <= 5'd0;
    end else begin
      wb_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            pc_r      <= in_pc;
            inst_r    <= in_inst;
            rd_r      <= in_rd;
            alu_r     <= in_alu;
            wb_pc_r   <= in_pc;
            wb_inst_r <= in_inst;
            wb_rd_r   <= in_rd;
            if (!is_mem_s) begin
              wb_valid_r <= 1'b1;
              wb_exc_r   <= 1'b0;
              wb_cause_r <= 4'd0;
              wb_data_r  <= in_is_sys ? in_csr_data : in_alu;
            end else if (misaligned_s) begin
              wb_valid_r <= 1'b1;
              wb_exc_r   <= 1'b1;
              wb_cause_r <= in_is_store ? 4'd6 : 4'd4;
              wb_data_r  <= in_alu;
            end else begin
              haddr_r  <= (CHECK_ALIGN != 0) ? in_alu : align_addr(in_inst[13:12], in_alu);
              hwrite_r <= in_is_store;
              hsize_r  <= {1'b0, in_inst[13:12]};
              hwdata_r <= store_lanes(in_inst[13:12], in_rs2);
              htrans_r <= HTRANS_NONSEQ;
              ready_r  <= 1'b0;
              state_r  <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (ahb.HREADY_D) begin
            htrans_r <= HTRANS_IDLE;
            state_r  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (ahb.HRESP_D && !ahb.HREADY_D) begin
            state_r <= ST_ERR;
          end else if (ahb.HREADY_D) begin
            // An ERROR response seen with HREADY high still terminates the transfer as a fault.
            wb_valid_r <= 1'b1;
            wb_pc_r    <= pc_r;
            wb_inst_r  <= inst_r;
            wb_rd_r    <= rd_r;
            wb_exc_r   <= ahb.HRESP_D;
            wb_cause_r <= ahb.HRESP_D ? (hwrite_r ? 4'd7 : 4'd5) : 4'd0;
            wb_data_r  <= (hwrite_r || ahb.HRESP_D) ? alu_r
                          : load_extract(inst_r[14:12], haddr_r[1:0], ahb.HRDATA_D);
            ready_r    <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (ahb.HREADY_D) begin
            wb_valid_r <= 1'b1;
            wb_pc_r    <= pc_r;
            wb_inst_r  <= inst_r;
            wb_rd_r    <= rd_r;
            wb_exc_r   <= 1'b1;
            wb_cause_r <= hwrite_r ? 4'd7 : 4'd5;
            wb_data_r  <= alu_r;
            ready_r    <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          htrans_r <= HTRANS_IDLE;
          ready_r  <= 1'b1;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating count of address/data-phase cycles stretched by the slave.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_ADDR || state_r == ST_DATA) && !ahb.HREADY_D
                 && (wait_cnt_r != {CNT_W{1'b1}})) begin
      wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready        = ready_r;
  assign ahb.HADDR_D     = haddr_r;
  assign ahb.HWDATA_D    = hwdata_r;
  assign ahb.HWRITE_D    = hwrite_r;
  assign ahb.HSIZE_D     = hsize_r;
  assign ahb.HTRANS_D    = htrans_r;
  assign ahb.HBURST_D    = 3'b000;
  assign ahb.HMASTLOCK_D = 1'b0;
  assign ahb.HPROT_D     = HPROT_VAL;
  assign wb_valid        = wb_valid_r;
  assign wb_pc           = wb_pc_r;
  assign wb_inst         = wb_inst_r;
  assign wb_data         = wb_data_r;
  assign wb_rd           = wb_rd_r;
  assign wb_exc          = wb_exc_r;
  assign wb_cause        = wb_cause_r;
  assign wait_cnt        = wait_cnt_r;
endmodule

// File: tb/tb_mem_stage_ahb.sv
// Randomized scoreboard bench for mem_stage_ahb: the stimulus process plays the
// pipeline and the AHB slave, a monitor process checks every write-back strobe.
module tb_mem_stage_ahb;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = 32'h0, in_inst = 32'h0, in_alu = 32'h0, in_rs2 = 32'h0, in_csr_data = 32'h0;
  logic [4:0]  in_rd = 5'd0;
  logic        in_is_load = 1'b0, in_is_store = 1'b0, in_is_sys = 1'b0;
  logic        wb_valid, wb_exc;
  logic [31:0] wb_pc, wb_inst, wb_data;
  logic [4:0]  wb_rd;
  logic [3:0]  wb_cause;
  logic [31:0] wait_cnt;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exc;
    logic [3:0]  cause;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_wait = 32'd0;

  mem_stage_ahb_if bus ();

  mem_stage_ahb dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_alu(in_alu), .in_rs2(in_rs2), .in_csr_data(in_csr_data),
    .in_rd(in_rd), .in_is_load(in_is_load), .in_is_store(in_is_store), .in_is_sys(in_is_sys),
    .ahb(bus),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_exc(wb_exc), .wb_cause(wb_cause), .wait_cnt(wait_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference load result: pick the addressed lane and extend it arithmetically.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] lane;
    lane = rdata >> (8 * addr[1:0]);
    case (f3)
      3'd0:    return (lane & 32'hFF) - ((lane & 32'h80) << 1);
      3'd1:    return (lane & 32'hFFFF) - ((lane & 32'h8000) << 1);
      3'd4:    return lane & 32'hFF;
      3'd5:    return lane & 32'hFFFF;
      default: return lane;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3[1:0])
      2'd0:    return (rs2 & 32'hFF) * 32'h01010101;
      2'd1:    return (rs2 & 32'hFFFF) * 32'h00010001;
      default: return rs2;
    endcase
  endfunction

  // Monitor: every write-back strobe must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb actual=wb_valid=1 pc=0x%08h expected=no strobe", wb_pc);
      end else begin
        e = exp_q.pop_front();
        chk("wb_pc", wb_pc, e.pc);
        chk("wb_inst", wb_inst, e.inst);
        chk("wb_data", wb_data, e.data);
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_exc", 32'(wb_exc), 32'(e.exc));
        chk("wb_cause", 32'(wb_cause), 32'(e.cause));
      end
    end
  end

  // One request; the bench acts as slave with aw/dw wait states, em error mode
  // (0 none, 1 two-cycle ERROR, 2 ERROR with HREADY high) and ew extra ERR stalls.
  task automatic run_txn(input bit ld, input bit st, input bit sy, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] rdata,
                         input int aw, input int dw, input int em, input int ew);
    exp_t        e;
    logic [31:0] inst, pc, csr;
    logic [4:0]  rd;
    bit          mem, mis;
    pc   = $urandom;
    csr  = $urandom;
    rd   = 5'($urandom);
    inst = $urandom;
    inst[14:12] = f3;
    mem  = ld || st;
    mis  = mem && ((alu % (32'd1 << f3[1:0])) != 32'd0);
    e.pc = pc; e.inst = inst; e.rd = rd; e.exc = 1'b0; e.cause = 4'd0;
    if (!mem) e.data = sy ? csr : alu;
    else if (mis) begin e.exc = 1'b1; e.cause = st ? 4'd6 : 4'd4; e.data = alu; end
    else if (em != 0) begin e.exc = 1'b1; e.cause = st ? 4'd7 : 4'd5; e.data = alu; end
    else e.data = st ? alu : model_load(f3, alu, rdata);
    exp_q.push_back(e);

    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_pc = pc; in_inst = inst; in_alu = alu; in_rs2 = rs2; in_csr_data = csr;
    in_rd = rd; in_is_load = ld; in_is_store = st; in_is_sys = sy;
    bus.HREADY_D = 1'($urandom); bus.HRESP_D = 1'b0; bus.HRDATA_D = $urandom;
    @(negedge CLK);
    if (!mem || mis) begin
      in_valid = 1'b0;
      chk("htrans_no_xfer", 32'(bus.HTRANS_D), 32'd0);
    end else begin
      for (int i = 0; i <= aw; i++) begin
        chk("htrans_nonseq", 32'(bus.HTRANS_D), 32'd2);
        chk("haddr", bus.HADDR_D, alu);
        chk("hwrite", 32'(bus.HWRITE_D), 32'(st));
        chk("hsize", 32'(bus.HSIZE_D), 32'(f3[1:0]));
        chk("hburst_lock_prot", {27'd0, bus.HMASTLOCK_D, bus.HBURST_D, 1'b0},
            {27'd0, 1'b0, 3'b000, 1'b0});
        chk("hprot", 32'(bus.HPROT_D), 32'd1);
        chk("no_early_wb", 32'(wb_valid), 32'd0);
        bus.HREADY_D = (i == aw); bus.HRESP_D = 1'b0; bus.HRDATA_D = $urandom;
        @(negedge CLK);
      end
      for (int i = 0; i <= dw; i++) begin
        chk("htrans_idle_data", 32'(bus.HTRANS_D), 32'd0);
        chk("no_early_wb", 32'(wb_valid), 32'd0);
        if (st) chk("hwdata", bus.HWDATA_D, model_wdata(f3, rs2));
        if (i < dw) begin
          bus.HREADY_D = 1'b0; bus.HRESP_D = 1'b0; bus.HRDATA_D = $urandom;
          @(negedge CLK);
        end
      end
      if (em == 1) begin
        bus.HREADY_D = 1'b0; bus.HRESP_D = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < ew; i++) begin
          chk("no_early_wb_err", 32'(wb_valid), 32'd0);
          @(negedge CLK);
        end
        bus.HREADY_D = 1'b1; bus.HRESP_D = 1'b1;
      end else begin
        bus.HREADY_D = 1'b1; bus.HRESP_D = (em == 2); bus.HRDATA_D = rdata;
      end
      in_valid = 1'b0;
      @(negedge CLK);
      exp_wait += 32'(aw + dw + ((em == 1) ? 1 : 0));
    end
    chk("wb_latency", 32'(wb_valid), 32'd1);
    bus.HREADY_D = 1'($urandom); bus.HRESP_D = 1'b0;
    @(negedge CLK);
    chk("wait_cnt", wait_cnt, exp_wait);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lf[5] = '{0, 1, 2, 4, 5};
    int   op, em;
    logic [31:0] a;
    bus.HREADY_D = 1'b1; bus.HRESP_D = 1'b0; bus.HRDATA_D = 32'h0;
    repeat (3) @(negedge CLK);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_htrans", 32'(bus.HTRANS_D), 32'd0);
    chk("rst_wb_exc_cause", {27'd0, wb_exc, wb_cause}, 32'd0);
    chk("rst_wb_pc", wb_pc, 32'd0);
    chk("rst_wb_inst", wb_inst, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wait_cnt", wait_cnt, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    run_txn(1, 0, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);
    run_txn(1, 0, 0, 3'd0, 32'h103, 32'h0, 32'h80000000, 0, 0, 0, 0);
    run_txn(1, 0, 0, 3'd4, 32'h103, 32'h0, 32'h80000000, 0, 0, 0, 0);
    run_txn(0, 1, 0, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 0, 0, 0, 0);
    run_txn(1, 0, 0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0, 0, 0);
    run_txn(0, 1, 0, 3'd2, 32'h200, 32'hCAFEF00D, 32'h0, 0, 3, 0, 0);
    chk("wait_cnt_sw3", wait_cnt, 32'd3);
    run_txn(1, 0, 0, 3'd2, 32'h300, 32'h0, 32'h0, 0, 0, 1, 0);
    run_txn(0, 1, 0, 3'd0, 32'h301, 32'h55, 32'h0, 0, 0, 2, 0);
    run_txn(0, 0, 1, 3'd0, 32'h12345678, 32'h0, 32'h0, 0, 0, 0, 0);

    // Reset while the load sits in its data phase: the transfer is dropped silently.
    in_valid = 1'b1; in_pc = 32'h40; in_inst = 32'h00002003; in_alu = 32'h400; in_rd = 5'd3;
    in_is_load = 1'b1; in_is_store = 1'b0; in_is_sys = 1'b0; bus.HREADY_D = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    bus.HREADY_D = 1'b0; RST = 1'b1; in_valid = 1'b0;
    @(negedge CLK);
    chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_htrans", 32'(bus.HTRANS_D), 32'd0);
    chk("mid_rst_wb_pc", wb_pc, 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    chk("mid_rst_wait_cnt", wait_cnt, 32'd0);
    RST = 1'b0; exp_wait = 32'd0; bus.HREADY_D = 1'b1;
    @(negedge CLK);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    run_txn(1, 0, 0, 3'd2, 32'h500, 32'h0, 32'h13579BDF, 0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 3);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      em = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      case (op)
        0: run_txn(0, 0, 0, 3'($urandom), a, 32'h0, 32'h0, 0, 0, 0, 0);
        1: run_txn(0, 0, 1, 3'($urandom), a, 32'h0, 32'h0, 0, 0, 0, 0);
        2: run_txn(1, 0, 0, 3'(lf[$urandom_range(0, 4)]), a, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 3), em, $urandom_range(0, 1));
        default: run_txn(0, 1, 0, 3'($urandom_range(0, 2)), a, $urandom, $urandom,
                         $urandom_range(0, 2), $urandom_range(0, 3), em, $urandom_range(0, 1));
      endcase
    end

    repeat (2) @(negedge CLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
